// File: rtl/keypad_encoder.sv
// keypad_encoder: 4x4 matrix keypad scanner, debouncer and hex encoder.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   row[3:0]   keypad rows, active-low, row[0] = top row
//   col[3:0]   column drive, active-low one-cold, col[0] = left column
//   key_code   hex code of the last accepted key
//   key_valid  one-clk pulse when key_code is updated
//   key_held   high while the accepted key is still down
//
// Key map (row, col): r0: 1 2 3 A / r1: 4 5 6 B / r2: 7 8 9 C / r3: E 0 F D
module keypad_encoder #(
    parameter int SCAN_DIV       = 5000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_TICKS   = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    if (SCAN_DIV < 2 || DEBOUNCE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_params
        $error("keypad_encoder: illegal parameter values");
    end

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED
    } state_t;

    state_t        state;
    logic [DW-1:0] div;
    logic          tick;
    logic [3:0]    rs1;
    logic [3:0]    rs;
    logic [3:0]    cap;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [3:0]    low;
    logic          one_low;
    logic [3:0]    col_rot;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    logic [RW-1:0] rep;
    logic [RW-1:0] rep_inc;
    assign rep_inc = rep + 1'b1;
`endif

    // Row and column indices come from plain OR encoders so that
    // patterns with several lows never trip a decoder assertion.
    function automatic logic [3:0] keymap(input logic [3:0] rp,
                                          input logic [3:0] cp);
        logic [3:0] idx;
        logic [3:0] code;
        idx = {~rp[2] | ~rp[3], ~rp[1] | ~rp[3],
               ~cp[2] | ~cp[3], ~cp[1] | ~cp[3]};
        case (idx)
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'hE;
            4'hD:    code = 4'h0;
            4'hE:    code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign tick    = (div == DW'(SCAN_DIV - 1));
    assign cnt_inc = cnt + 1'b1;
    assign low     = ~rs;
    // Exactly one row low: non-zero and a power of two.
    assign one_low = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
    assign col_rot = {col[2:0], col[3]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SCAN;
            col       <= 4'b1110;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            div       <= '0;
            cnt       <= '0;
            rs1       <= 4'hF;
            rs        <= 4'hF;
            cap       <= 4'hF;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep       <= '0;
`endif
        end else begin
            rs1       <= row;
            rs        <= rs1;
            key_valid <= 1'b0;
            div       <= tick ? '0 : div + 1'b1;
            if (tick) begin
                unique case (state)
                    SCAN: begin
                        if (one_low) begin
                            cap <= rs;
                            if (DEBOUNCE_TICKS == 1) begin
                                state     <= PRESSED;
                                key_code  <= keymap(rs, col);
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt       <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                                rep       <= '0;
`endif
                            end else begin
                                state <= DEBOUNCE;
                                cnt   <= CW'(1);
                            end
                        end else begin
                            col <= col_rot;
                        end
                    end
                    DEBOUNCE: begin
                        if (rs == cap) begin
                            if (cnt_inc == CW'(DEBOUNCE_TICKS)) begin
                                state     <= PRESSED;
                                key_code  <= keymap(cap, col);
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt       <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                                rep       <= '0;
`endif
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            state <= SCAN;
                            cnt   <= '0;
                            col   <= col_rot;
                        end
                    end
                    PRESSED: begin
                        // Column stays parked; only a clean all-high
                        // pattern counts towards the release.
                        if (rs == 4'hF) begin
                            if (cnt_inc == CW'(DEBOUNCE_TICKS)) begin
                                state    <= SCAN;
                                key_held <= 1'b0;
                                cnt      <= '0;
                                col      <= col_rot;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            cnt <= '0;
                        end
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (rs == cap) begin
                            if (rep_inc == RW'(REPEAT_TICKS)) begin
                                key_valid <= 1'b1;
                                rep       <= '0;
                            end else begin
                                rep <= rep_inc;
                            end
                        end else begin
                            rep <= '0;
                        end
`endif
                    end
                    default: begin
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: keypad model, vector table and pulse scoreboard.
// Expected codes are queued on press and popped on each key_valid.
module tb_keypad_encoder;

    localparam int SD = 4;
    localparam int DT = 3;
    localparam int RT = 5;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] keys;
    int          n_cmp = 0;
    int          n_err = 0;
    int          pulses = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  last_code = 4'h0;
    bit          rep_ok = 1'b0;

    typedef struct {
        int         r;
        int         c;
        logic [3:0] code;
    } vec_t;

    vec_t vecs[7];

    keypad_encoder #(
        .SCAN_DIV      (SD),
        .DEBOUNCE_TICKS(DT),
        .REPEAT_TICKS  (RT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its row low while its
    // column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act,
                             input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step();
        logic [3:0] e;
        @(negedge clk);
        if (key_valid) begin
            pulses++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                last_code = e;
                chk("pulse_code", key_code, e);
            end else if (rep_ok) begin
                chk("repeat_code", key_code, last_code);
            end else begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: got key_code %0h, expected no pulse",
                         key_code);
            end
        end
    endtask

    task automatic wait_valid(input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!key_valid && n < bound);
        if (!key_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout_valid: got no key_valid in %0d clk, expected one",
                     bound);
        end
    endtask

    task automatic hold_release(input int n0, input logic [3:0] code,
                                input int hold);
        int n;
        chk("held_on_accept", key_held, 1'b1);
        rep_ok = REP_EN;
        for (int i = n0; i < hold; i++) step();
        chk("held_while_down", key_held, 1'b1);
        keys = '0;
        n = 0;
        do begin
            step();
            n++;
        end while (key_held && n < 100);
        rep_ok = 1'b0;
        chk_range("release_delay", n, 11, 14);
        chk("code_holds", key_code, code);
        repeat (8) step();
    endtask

    function automatic logic [3:0] rotl(input logic [3:0] v, input int k);
        logic [3:0] t;
        t = v;
        for (int i = 0; i < k; i++) t = {t[2:0], t[3]};
        return t;
    endfunction

    initial begin
        int n;
        int trans;
        logic [3:0] prev;

        vecs[0] = '{r: 1, c: 1, code: 4'h5};
        vecs[1] = '{r: 3, c: 1, code: 4'h0};
        vecs[2] = '{r: 2, c: 2, code: 4'h9};
        vecs[3] = '{r: 0, c: 3, code: 4'hA};
        vecs[4] = '{r: 3, c: 3, code: 4'hD};
        vecs[5] = '{r: 2, c: 0, code: 4'h7};
        vecs[6] = '{r: 1, c: 3, code: 4'hB};

        keys    = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_col", col, 4'b1110);
        chk("rst_code", key_code, 4'h0);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_held", key_held, 1'b0);
        reset_n = 1'b1;

        // Idle scan: one rotation every SD clocks from reset release.
        for (int k = 0; k < 40; k++) begin
            chk("idle_col", col, rotl(4'b1110, (k / SD) % 4));
            step();
        end
        chk("idle_code", key_code, 4'h0);

        foreach (vecs[i]) begin
            exp_q.push_back(vecs[i].code);
            keys = '0;
            keys[vecs[i].r*4+vecs[i].c] = 1'b1;
            wait_valid(60, n);
            hold_release(n, vecs[i].code, 60);
        end

        // Bounce on key "1" then a stable press.
        for (int i = 0; i < 10; i++) begin
            keys[0] = (i % 2 == 0);
            repeat (3) step();
        end
        exp_q.push_back(4'h1);
        keys[0] = 1'b1;
        wait_valid(60, n);
        hold_release(n, 4'h1, 60);

        // "A" and "D" together: ambiguous, scanning must not stop.
        keys = '0;
        keys[0*4+3] = 1'b1;
        keys[3*4+3] = 1'b1;
        prev = col;
        trans = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (col != prev) trans++;
            prev = col;
        end
        chk("twokey_rotations", trans, 15);
        keys = '0;
        repeat (8) step();

        // "#" pressed, reset lands mid-debounce.
        n = 0;
        while (col != 4'b0111 && n < 40) begin
            step();
            n++;
        end
        chk("reach_col3", col, 4'b0111);
        keys[3*4+2] = 1'b1;
        n = 0;
        while (col != 4'b1011 && n < 40) begin
            step();
            n++;
        end
        chk("reach_col2", col, 4'b1011);
        repeat (5) step();
        reset_n = 1'b0;
        #1;
        chk("midrst_col", col, 4'b1110);
        chk("midrst_code", key_code, 4'h0);
        chk("midrst_valid", key_valid, 1'b0);
        chk("midrst_held", key_held, 1'b0);
        repeat (2) step();
        reset_n = 1'b1;
        exp_q.push_back(4'hF);
        wait_valid(100, n);
        chk("rearm_latency", n, 20);
        hold_release(n, 4'hF, 60);

        // "*" held for 200 clk.
        pulses = 0;
        exp_q.push_back(4'hE);
        keys[3*4+0] = 1'b1;
        wait_valid(60, n);
        hold_release(n, 4'hE, 200);
`ifdef KEYPAD_AUTOREPEAT_EN
        chk_range("repeat_pulses", pulses, 7, 12);
`else
        chk("single_pulse", pulses, 1);
`endif

        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
